// File: rtl/lsu_split_ctrl_if.sv
// Request, memory-port and response signals of the load/store sequencer.
// slave: the sequencer itself; master: the EX stage plus memory side that drives it.
interface lsu_split_ctrl_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_type_i;
  logic        req_sext_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        mem_req_o;
  logic        mem_gnt_i;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_err_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  modport slave (
    input  req_valid_i, req_we_i, req_type_i, req_sext_i, req_addr_i, req_wdata_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
    output req_ready_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport master (
    output req_valid_i, req_we_i, req_type_i, req_sext_i, req_addr_i, req_wdata_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
    input  req_ready_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/lsu_split_ctrl.sv
// Load/store sequencer: byte-enables, lane shift, misaligned split into two word beats, load merge/extend.
// Latency: 4 cycles accept->rsp (6 when split) with same-cycle grant and next-cycle rvalid.
// Backpressure: one access in flight; req_ready_o only in IDLE, mem_* held until mem_gnt_i.
module lsu_split_ctrl #(
  parameter bit MISALIGN_ERR = 1'b0
) (
  input logic           clk_i,
  input logic           rst_ni,
  lsu_split_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, REQ1, WAIT1, REQ2, WAIT2, RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q, sext_q, err_q;
  logic [1:0]  type_q;
  logic [31:0] addr_q, wdata_q, beat0_q, beat1_q;

  logic [1:0]  off;
  logic        split;
  logic [3:0]  be_base;
  logic [7:0]  be_wide;
  logic [63:0] wdata_wide;
  logic [31:0] addr_al, merged, load_data;

  // Access crosses a word boundary: half at offset 3, or any unaligned word.
  function automatic logic crosses(input logic [1:0] t, input logic [1:0] o);
    return (t == 2'b01 && o == 2'b11) || (t[1] && o != 2'b00);
  endfunction

  assign off        = addr_q[1:0];
  assign split      = crosses(type_q, off);
  assign addr_al    = {addr_q[31:2], 2'b00};
  assign be_base    = type_q[1] ? 4'b1111 : (type_q[0] ? 4'b0011 : 4'b0001);
  assign be_wide    = {4'b0000, be_base} << off;
  assign wdata_wide = {32'b0, wdata_q} << {off, 3'b000};
  assign merged     = 32'({beat1_q, beat0_q} >> {off, 3'b000});

  always_comb begin
    load_data = merged;
    case (type_q)
      2'b00:   load_data = {{24{sext_q & merged[7]}}, merged[7:0]};
      2'b01:   load_data = {{16{sext_q & merged[15]}}, merged[15:0]};
      default: load_data = merged;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    bus.req_ready_o = 1'b0;
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_be_o    = 4'b0000;
    bus.mem_addr_o  = 32'b0;
    bus.mem_wdata_o = 32'b0;
    bus.rsp_valid_o = 1'b0;
    bus.rsp_rdata_o = 32'b0;
    bus.rsp_err_o   = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready_o = 1'b1;
        if (bus.req_valid_i) begin
          if (MISALIGN_ERR && crosses(bus.req_type_i, bus.req_addr_i[1:0])) state_d = RESP;
          else                                                              state_d = REQ1;
        end
      end
      REQ1: begin
        bus.mem_req_o   = 1'b1;
        bus.mem_we_o    = we_q;
        bus.mem_be_o    = be_wide[3:0];
        bus.mem_addr_o  = addr_al;
        bus.mem_wdata_o = wdata_wide[31:0];
        if (bus.mem_gnt_i) state_d = WAIT1;
      end
      WAIT1: if (bus.mem_rvalid_i) state_d = (split && !bus.mem_err_i) ? REQ2 : RESP;
      REQ2: begin
        bus.mem_req_o   = 1'b1;
        bus.mem_we_o    = we_q;
        bus.mem_be_o    = be_wide[7:4];
        bus.mem_addr_o  = addr_al + 32'd4;
        bus.mem_wdata_o = wdata_wide[63:32];
        if (bus.mem_gnt_i) state_d = WAIT2;
      end
      WAIT2: if (bus.mem_rvalid_i) state_d = RESP;
      RESP: begin
        bus.rsp_valid_o = 1'b1;
        bus.rsp_err_o   = err_q;
        bus.rsp_rdata_o = (we_q || err_q) ? 32'b0 : load_data;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      err_q   <= 1'b0;
      type_q  <= 2'b00;
      addr_q  <= 32'b0;
      wdata_q <= 32'b0;
      beat0_q <= 32'b0;
      beat1_q <= 32'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (bus.req_valid_i) begin
          we_q    <= bus.req_we_i;
          type_q  <= bus.req_type_i;
          sext_q  <= bus.req_sext_i;
          addr_q  <= bus.req_addr_i;
          wdata_q <= bus.req_wdata_i;
          beat0_q <= 32'b0;
          beat1_q <= 32'b0;
          err_q   <= MISALIGN_ERR && crosses(bus.req_type_i, bus.req_addr_i[1:0]);
        end
        WAIT1: if (bus.mem_rvalid_i) begin
          beat0_q <= bus.mem_rdata_i;
          err_q   <= bus.mem_err_i;
        end
        WAIT2: if (bus.mem_rvalid_i) begin
          beat1_q <= bus.mem_rdata_i;
          err_q   <= err_q | bus.mem_err_i;
        end
        default: ;
      endcase
    end
  end

endmodule
